// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RV32I core.
// Accepts one load/store per handshake, inserts WAIT wait states, performs
// byte/half/word access with load extension and store lane merging, and
// returns a one-cycle response flagging misaligned or illegal requests.
module dmem_responder #(
  parameter int WIDTH = 32,
  parameter int DADDR = 10,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [DADDR-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int DEPTH = 2 ** (DADDR - 2);
  localparam int CW    = (WAIT < 2) ? 1 : $clog2(WAIT);
  localparam logic [CW-1:0] CNT_LOAD = (WAIT > 0) ? CW'(WAIT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  // Captured request fields, used when the access happens after wait states
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [DADDR-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_access;
  logic             w_err_nxt;

  // Operands of the access: live inputs when the access coincides with the
  // accept edge (WAIT=0), captured copies otherwise.
  logic             w_we;
  logic [2:0]       w_funct3;
  logic [DADDR-1:0] w_addr;
  logic [WIDTH-1:0] w_wdata;

  logic [DADDR-3:0] w_idx;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_wword;
  logic [WIDTH-1:0] w_rd;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_mem_we;

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_accept  = req_valid & req_ready;

  // Legality of the presented request: funct3 set and natural alignment
  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'd0:    w_legal = 1'b1;
      3'd1:    w_legal = ~req_addr[0];
      3'd2:    w_legal = (req_addr[1:0] == 2'b00);
      3'd4:    w_legal = ~req_we;
      3'd5:    w_legal = ~req_we & ~req_addr[0];
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state, wait counter and access strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
          end else if (WAIT == 0) begin
            w_state_nxt = S_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Access operand select
  always_comb begin
    if (r_state == S_IDLE) begin
      w_we     = req_we;
      w_funct3 = req_funct3;
      w_addr   = req_addr;
      w_wdata  = req_wdata;
    end else begin
      w_we     = r_we;
      w_funct3 = r_funct3;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
    end
  end

  assign w_idx    = w_addr[DADDR-1:2];
  assign w_word   = r_mem[w_idx];
  assign w_byte   = 8'(w_word >> {w_addr[1:0], 3'b000});
  assign w_half   = 16'(w_word >> {w_addr[1], 4'b0000});
  assign w_mem_we = w_access & w_we & reset_n;

  // Load extension; stores return zero
  always_comb begin
    w_rd = '0;
    if (!w_we) begin
      case (w_funct3)
        3'd0:    w_rd = {{24{w_byte[7]}}, w_byte};
        3'd4:    w_rd = {24'h000000, w_byte};
        3'd1:    w_rd = {{16{w_half[15]}}, w_half};
        3'd5:    w_rd = {16'h0000, w_half};
        3'd2:    w_rd = w_word;
        default: w_rd = '0;
      endcase
    end
  end

  // Store lane merge into the addressed word
  always_comb begin
    w_wword = w_word;
    case (w_funct3[1:0])
      2'd0:    w_wword[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
      2'd1:    w_wword[{w_addr[1], 4'b0000} +: 16] = w_wdata[15:0];
      default: w_wword = w_wdata;
    endcase
  end

  // Memory array write (contents not reset)
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_wword;
    end
  end

  // Response data and error, registered on RESP entry and cleared otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= w_access ? w_rd : '0;
      r_err   <= w_err_nxt;
    end
  end

endmodule
